// File: rtl/atmega_adc_sequencer_pkg.sv
// Shared definitions for the ATmega-style ADC sequencer: register map defaults,
// ADCSRA bit positions, auto-trigger source codes and FSM state encoding.
package atmega_adc_sequencer_pkg;

  localparam int unsigned ADCL_ADDR_DEF   = 32'h78;
  localparam int unsigned ADCH_ADDR_DEF   = 32'h79;
  localparam int unsigned ADCSRA_ADDR_DEF = 32'h7A;
  localparam int unsigned ADCSRB_ADDR_DEF = 32'h7B;
  localparam int unsigned ADMUX_ADDR_DEF  = 32'h7C;

  localparam int ADEN_BIT  = 7;
  localparam int ADSC_BIT  = 6;
  localparam int ADATE_BIT = 5;
  localparam int ADIF_BIT  = 4;
  localparam int ADIE_BIT  = 3;
  localparam int ADLAR_BIT = 5;

  localparam logic [2:0] ADTS_FREE_RUN = 3'b000;
  localparam logic [2:0] ADTS_EXT_TRIG = 3'b001;

  localparam int CONV_TICKS_DEF   = 13;
  localparam int FIRST_CONV_EXTRA = 12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CONVERT   = 2'd1,
    ST_WAIT_DATA = 2'd2
  } adc_state_e;

  // Returns {ADCH, ADCL} for a 10-bit result under the given justification.
  function automatic logic [15:0] justify_result(input logic [9:0] d, input logic adlar);
    if (adlar) return {d, 6'b000000};
    return {6'b000000, d};
  endfunction

endpackage

// File: rtl/atmega_adc_prescaler.sv
// ADC clock prescaler: one-cycle tick every 2^max(adps,1) clk cycles while enabled;
// the counter is held at zero while disabled.
module atmega_adc_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] adps,
  output logic       tick
);

  logic [6:0] cnt;
  logic [6:0] mask;

  always_comb begin
    mask = 7'h01;
    case (adps)
      3'd0, 3'd1: mask = 7'h01;
      3'd2:       mask = 7'h03;
      3'd3:       mask = 7'h07;
      3'd4:       mask = 7'h0F;
      3'd5:       mask = 7'h1F;
      3'd6:       mask = 7'h3F;
      default:    mask = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 7'd0;
    end else if (!en) begin
      cnt <= 7'd0;
    end else begin
      cnt <= cnt + 7'd1;
    end
  end

  // Free-running counter; a change of adps simply re-masks the running count.
  assign tick = en && ((cnt & mask) == mask);

endmodule

// File: rtl/atmega_adc_sequencer.sv
// ATmega-style ADC conversion sequencer: register file, prescaled conversion timing,
// sample-source handshake, result justification/locking and interrupt flag.
module atmega_adc_sequencer
  import atmega_adc_sequencer_pkg::*;
#(
  parameter int          BUS_ADDR_DATA_LEN = 8,
  parameter int unsigned ADCL_ADDR         = ADCL_ADDR_DEF,
  parameter int unsigned ADCH_ADDR         = ADCH_ADDR_DEF,
  parameter int unsigned ADCSRA_ADDR       = ADCSRA_ADDR_DEF,
  parameter int unsigned ADCSRB_ADDR       = ADCSRB_ADDR_DEF,
  parameter int unsigned ADMUX_ADDR        = ADMUX_ADDR_DEF,
  parameter int          CONV_TICKS        = CONV_TICKS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic                         sample_req,
  input  logic                         sample_ack,
  input  logic [9:0]                   sample_data,
  input  logic                         ext_trig,
  output logic                         int_req,
  input  logic                         int_ack,
  output logic [1:0]                   dbg_state
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_ADCL   = ADCL_ADDR[BUS_ADDR_DATA_LEN-1:0];
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_ADCH   = ADCH_ADDR[BUS_ADDR_DATA_LEN-1:0];
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_ADCSRA = ADCSRA_ADDR[BUS_ADDR_DATA_LEN-1:0];
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_ADCSRB = ADCSRB_ADDR[BUS_ADDR_DATA_LEN-1:0];
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_ADMUX  = ADMUX_ADDR[BUS_ADDR_DATA_LEN-1:0];
  localparam logic [7:0] LEN_NORMAL = 8'(CONV_TICKS);
  localparam logic [7:0] LEN_FIRST  = 8'(CONV_TICKS + FIRST_CONV_EXTRA);

  adc_state_e state, state_d;
  logic [7:0] tick_cnt, tick_cnt_d;
  logic       aden, adsc, adate, adif, adie;
  logic [2:0] adps, adts;
  logic [7:0] admux;
  logic [9:0] result;
  logic       lock, first_conv, ext_trig_q;

  logic        tick;
  logic        wr_adcsra, start_wr, aden_off, free_run, trig_start;
  logic        start_acc, done, abort;
  logic [7:0]  conv_len;
  logic [15:0] just;

  atmega_adc_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (aden),
    .adps (adps),
    .tick (tick)
  );

  assign wr_adcsra  = wr && (addr == A_ADCSRA);
  assign start_wr   = wr_adcsra && bus_in[ADEN_BIT] && bus_in[ADSC_BIT];
  assign aden_off   = wr_adcsra && !bus_in[ADEN_BIT];
  assign free_run   = adate && (adts == ADTS_FREE_RUN);
  assign trig_start = aden && adate && (adts == ADTS_EXT_TRIG) && ext_trig && !ext_trig_q;
  assign conv_len   = first_conv ? LEN_FIRST : LEN_NORMAL;

  // Sample handshake: sample_req is high for exactly the WAIT_DATA state and stays
  // high until sample_ack; sample_data is taken in the cycle sample_ack is high while
  // sample_req is high. An ack seen in any other state is ignored.
  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    start_acc  = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_wr || trig_start) begin
          state_d    = ST_CONVERT;
          tick_cnt_d = 8'd0;
          start_acc  = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (tick) begin
          if (tick_cnt == conv_len - 8'd1) begin
            state_d    = ST_WAIT_DATA;
            tick_cnt_d = 8'd0;
          end else begin
            tick_cnt_d = tick_cnt + 8'd1;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (sample_ack) begin
          done       = 1'b1;
          state_d    = free_run ? ST_CONVERT : ST_IDLE;
          tick_cnt_d = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling the ADC overrides everything, including a same-cycle ack.
    if (aden_off || (!aden && state != ST_IDLE)) begin
      abort      = 1'b1;
      state_d    = ST_IDLE;
      tick_cnt_d = 8'd0;
      start_acc  = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tick_cnt <= 8'd0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aden       <= 1'b0;
      adsc       <= 1'b0;
      adate      <= 1'b0;
      adif       <= 1'b0;
      adie       <= 1'b0;
      adps       <= 3'd0;
      adts       <= 3'd0;
      admux      <= 8'd0;
      result     <= 10'h000;
      lock       <= 1'b0;
      first_conv <= 1'b1;
      ext_trig_q <= 1'b0;
    end else begin
      ext_trig_q <= ext_trig;
      if (wr_adcsra) begin
        aden  <= bus_in[ADEN_BIT];
        adate <= bus_in[ADATE_BIT];
        adie  <= bus_in[ADIE_BIT];
        adps  <= bus_in[2:0];
      end
      if (wr && (addr == A_ADCSRB)) adts <= bus_in[2:0];
      if (wr && (addr == A_ADMUX)) admux <= bus_in;

      // ADSC is never cleared by software, only by completion or disable.
      if (abort)                      adsc <= 1'b0;
      else if (start_acc)             adsc <= 1'b1;
      else if (done && !free_run)     adsc <= 1'b0;

      if (done)                                         adif <= 1'b1;
      else if ((wr_adcsra && bus_in[ADIF_BIT]) || int_ack) adif <= 1'b0;

      if (done && !lock) result <= sample_data;

      if (rd && (addr == A_ADCL))      lock <= 1'b1;
      else if (rd && (addr == A_ADCH)) lock <= 1'b0;

      if (!aden)                                            first_conv <= 1'b1;
      else if (state == ST_CONVERT && state_d == ST_WAIT_DATA) first_conv <= 1'b0;
    end
  end

  assign just = justify_result(result, admux[ADLAR_BIT]);

  always_comb begin
    bus_out = 8'h00;
    if (rd) begin
      if (addr == A_ADCL)        bus_out = just[7:0];
      else if (addr == A_ADCH)   bus_out = just[15:8];
      else if (addr == A_ADCSRA) bus_out = {aden, adsc, adate, adif, adie, adps};
      else if (addr == A_ADCSRB) bus_out = {5'b00000, adts};
      else if (addr == A_ADMUX)  bus_out = admux;
    end
  end

  assign sample_req = (state == ST_WAIT_DATA);
  assign int_req    = adif && adie;
  assign dbg_state  = state;

endmodule

// File: tb/tb_atmega_adc_sequencer.sv
// Directed bench for atmega_adc_sequencer: conversion timing, justification,
// free-running, locking, abort, external trigger and asynchronous reset.
module tb_atmega_adc_sequencer;

  localparam logic [7:0] A_ADCL   = 8'h78;
  localparam logic [7:0] A_ADCH   = 8'h79;
  localparam logic [7:0] A_ADCSRA = 8'h7A;
  localparam logic [7:0] A_ADCSRB = 8'h7B;
  localparam logic [7:0] A_ADMUX  = 8'h7C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] bus_out;
  logic       sample_req;
  logic       sample_ack = 1'b0;
  logic [9:0] sample_data = 10'h000;
  logic       ext_trig = 1'b0;
  logic       int_req;
  logic       int_ack = 1'b0;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int en_edge = 0;
  int lat = 0;
  logic [15:0] exp_q[$];

  atmega_adc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wr          (wr),
    .rd          (rd),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .sample_req  (sample_req),
    .sample_ack  (sample_ack),
    .sample_data (sample_data),
    .ext_trig    (ext_trig),
    .int_req     (int_req),
    .int_ack     (int_ack),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: all are entered and left 1ns after a rising edge
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; bus_in = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = a; rd = 1'b1;
    #1 d = bus_out;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic wait_req(input string tag, input int bound, output int n);
    n = 0;
    while (!sample_req && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_req"}, {15'd0, sample_req}, 16'd1);
  endtask

  task automatic ack(input logic [9:0] d, input logic iack);
    sample_data = d; sample_ack = 1'b1; int_ack = iack;
    @(posedge clk); #1;
    sample_ack = 1'b0; int_ack = 1'b0; sample_data = 10'h000;
  endtask

  // scoreboard: pops the expected {ADCH, ADCL} and reads the pair in lock order
  task automatic check_result(input string tag);
    logic [7:0]  lo, hi;
    logic [15:0] e;
    e = exp_q.pop_front();
    bus_read(A_ADCL, lo);
    bus_read(A_ADCH, hi);
    check({tag, "_adcl"}, {8'h00, lo}, {8'h00, e[7:0]});
    check({tag, "_adch"}, {8'h00, hi}, {8'h00, e[15:8]});
  endtask

  initial begin
    // reset state
    #1;
    check("rst_sample_req", {15'd0, sample_req}, 16'd0);
    check("rst_int_req", {15'd0, int_req}, 16'd0);
    check("rst_state", {14'd0, dbg_state}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_rd("rst_adcsra", A_ADCSRA, 8'h00);
    check_rd("rst_adcsrb", A_ADCSRB, 8'h00);
    check_rd("rst_admux", A_ADMUX, 8'h00);
    exp_q.push_back(16'h0000);
    check_result("rst_result");

    // first conversion: ADPS=2, 25 ticks x 4 clk
    bus_write(A_ADCSRA, 8'hC2);
    en_edge = cyc;
    wait_req("conv1", 200, lat);
    check("conv1_latency", 16'(lat), 16'd100);
    check("conv1_state", {14'd0, dbg_state}, 16'd2);
    ack(10'h2A5, 1'b0);
    exp_q.push_back(16'h02A5);
    check_result("conv1");
    check_rd("conv1_adcsra", A_ADCSRA, 8'h92);
    check("conv1_int_req", {15'd0, int_req}, 16'd0);
    bus_write(A_ADCL, 8'h55);
    bus_write(A_ADCH, 8'h55);
    exp_q.push_back(16'h02A5);
    check_result("ro_result");

    // second conversion: ADPS=0, ADLAR=1, 13 ticks x 2 clk
    bus_write(A_ADMUX, 8'h20);
    bus_write(A_ADCSRA, 8'h90);
    check_rd("conv2_adcsra_pre", A_ADCSRA, 8'h80);
    if (((cyc + 1 - en_edge) % 2) != 0) begin
      @(posedge clk); #1;
    end
    bus_write(A_ADCSRA, 8'hC0);
    wait_req("conv2", 100, lat);
    check("conv2_latency", 16'(lat), 16'd26);
    ack(10'h3FF, 1'b0);
    exp_q.push_back(16'hFFC0);
    check_result("conv2_adlar1");
    bus_write(A_ADMUX, 8'h0F);
    check_rd("admux_readback", A_ADMUX, 8'h0F);
    exp_q.push_back(16'h03FF);
    check_result("conv2_adlar0");

    // free-running with interrupt
    bus_write(A_ADCSRB, 8'h00);
    bus_write(A_ADCSRA, 8'hF8);
    wait_req("fr1", 60, lat);
    ack(10'h111, 1'b0);
    check("fr1_int_req", {15'd0, int_req}, 16'd1);
    check("fr1_state", {14'd0, dbg_state}, 16'd1);
    check_rd("fr1_adcsra", A_ADCSRA, 8'hF8);
    exp_q.push_back(16'h0111);
    check_result("fr1");
    wait_req("fr2", 60, lat);
    ack(10'h222, 1'b1);
    check("fr2_set_wins", {15'd0, int_req}, 16'd1);
    int_ack = 1'b1;
    @(posedge clk); #1;
    int_ack = 1'b0;
    check("int_ack_clear", {15'd0, int_req}, 16'd0);
    exp_q.push_back(16'h0222);
    check_result("fr2");
    bus_write(A_ADCSRA, 8'h88);
    check_rd("fr_stop_adcsra", A_ADCSRA, 8'hC8);
    wait_req("fr3", 60, lat);
    ack(10'h0AB, 1'b0);
    check("fr3_state", {14'd0, dbg_state}, 16'd0);
    check_rd("fr3_adcsra", A_ADCSRA, 8'h98);
    check("fr3_int_req", {15'd0, int_req}, 16'd1);

    // result lock across a completing conversion
    bus_write(A_ADCSRA, 8'h90);
    check_rd("lock_adcl", A_ADCL, 8'hAB);
    bus_write(A_ADCSRA, 8'hC0);
    wait_req("lock", 60, lat);
    ack(10'h155, 1'b0);
    check_rd("lock_adch_old", A_ADCH, 8'h00);
    check_rd("lock_adcsra", A_ADCSRA, 8'h90);
    exp_q.push_back(16'h00AB);
    check_result("lock_discard");
    bus_write(A_ADCSRA, 8'hD0);
    wait_req("fresh", 60, lat);
    ack(10'h155, 1'b0);
    exp_q.push_back(16'h0155);
    check_result("fresh");

    // ADEN cleared during WAIT_DATA, then a late ack
    bus_write(A_ADCSRA, 8'hC0);
    wait_req("abort", 60, lat);
    bus_write(A_ADCSRA, 8'h00);
    check("abort_req", {15'd0, sample_req}, 16'd0);
    ack(10'h3C3, 1'b0);
    check("abort_state", {14'd0, dbg_state}, 16'd0);
    check_rd("abort_adcsra", A_ADCSRA, 8'h10);
    exp_q.push_back(16'h0155);
    check_result("abort");

    // external trigger (first conversion after ADEN rise)
    bus_write(A_ADCSRB, 8'h01);
    bus_write(A_ADCSRA, 8'hB0);
    repeat (5) @(posedge clk);
    #1 check("trig_idle", {14'd0, dbg_state}, 16'd0);
    ext_trig = 1'b1;
    @(posedge clk); #1;
    ext_trig = 1'b0;
    check("trig_state", {14'd0, dbg_state}, 16'd1);
    check_rd("trig_adcsra", A_ADCSRA, 8'hE0);
    wait_req("trig", 80, lat);
    ack(10'h0F0, 1'b0);
    check_rd("trig_done_adcsra", A_ADCSRA, 8'hB0);
    exp_q.push_back(16'h00F0);
    check_result("trig");

    // asynchronous reset mid-CONVERT
    bus_write(A_ADMUX, 8'h2F);
    bus_write(A_ADCSRA, 8'hC0);
    repeat (10) @(posedge clk);
    #1 check("pre_rst_state", {14'd0, dbg_state}, 16'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_state", {14'd0, dbg_state}, 16'd0);
    check("arst_sample_req", {15'd0, sample_req}, 16'd0);
    check("arst_int_req", {15'd0, int_req}, 16'd0);
    rd = 1'b1; addr = A_ADMUX;
    #1 check("arst_admux", {8'h00, bus_out}, 16'h0000);
    addr = A_ADCSRA;
    #1 check("arst_adcsra", {8'h00, bus_out}, 16'h0000);
    addr = A_ADCL;
    #1 check("arst_adcl", {8'h00, bus_out}, 16'h0000);
    rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_state", {14'd0, dbg_state}, 16'd0);
    check("post_rst_req", {15'd0, sample_req}, 16'd0);
    check_rd("post_rst_adcsra", A_ADCSRA, 8'h00);
    check("exp_q_empty", 16'(exp_q.size()), 16'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/atmega_adc_sequencer.md
ATMEGA_ADC_SEQUENCER -- requirements
Module: atmega_adc_sequencer

Interface
REQ-001 Parameter BUS_ADDR_DATA_LEN, 8, width of addr bus.
REQ-002 Parameters ADCL_ADDR 'h78, ADCH_ADDR 'h79, ADCSRA_ADDR 'h7A, ADCSRB_ADDR 'h7B, ADMUX_ADDR 'h7C, register addresses.
REQ-003 Parameter CONV_TICKS, 13, ADC-clock ticks per normal conversion; first conversion after ADEN rise SHALL take CONV_TICKS+12.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 addr  input  BUS_ADDR_DATA_LEN  register address; wr, rd  input  1  write/read strobes; bus_in  input  8  write data; bus_out  output  8  read data, combinational, 0 when not addressed or rd low.
REQ-007 sample_req  output  1  request to random/sample source, held until acknowledged.
REQ-008 sample_ack  input  1  source handshake; sample_data  input  10  value valid in the cycle sample_ack is high.
REQ-009 ext_trig  input  1  external auto-trigger source, synchronous to clk.
REQ-010 int_req  output  1  interrupt = ADIF & ADIE; int_ack  input  1  one-cycle vector-taken pulse.

Function
REQ-011 ADCSRA bits SHALL be ADEN[7], ADSC[6], ADATE[5], ADIF[4], ADIE[3], ADPS[2:0]; ADCSRB[2:0] SHALL be ADTS; ADMUX[5] SHALL be ADLAR, other ADMUX bits stored and read back unused.
REQ-012 Prescaler SHALL produce a one-clk tick every 2^max(ADPS,1) clk cycles while ADEN=1; counter held at 0 while ADEN=0.
REQ-013 FSM states IDLE, CONVERT, WAIT_DATA; IDLE->CONVERT on start, CONVERT->WAIT_DATA when tick count reaches required length, WAIT_DATA->IDLE (or CONVERT if free-running) on sample_ack.
REQ-014 Start condition: write of ADSC=1 with ADEN=1 (in same or earlier write), or ADATE=1 and ADTS=001 and ext_trig rising edge while IDLE.
REQ-015 ADATE=1 with ADTS=000 SHALL restart conversion immediately after completion with ADSC remaining 1.
REQ-016 Start requests while in CONVERT or WAIT_DATA SHALL be ignored; writes of ADSC=0 SHALL have no effect.
REQ-017 sample_req SHALL be 1 exactly in WAIT_DATA; result latched on sample_ack cycle.
REQ-018 Result: ADLAR=0 -> ADCH={6'b0,d[9:8]}, ADCL=d[7:0]; ADLAR=1 -> ADCH=d[9:2], ADCL={d[1:0],6'b0}; ADLAR change after conversion SHALL re-justify the held 10-bit result immediately.
REQ-019 On completion ADIF SHALL set and ADSC SHALL clear (unless free-running).
REQ-020 Reading ADCL SHALL lock result register until ADCH read; a conversion completing while locked SHALL discard its data but still set ADIF.
REQ-021 ADIF SHALL clear on write of 1 to bit 4 or on int_ack; set event same cycle as clear SHALL win.
REQ-022 Clearing ADEN SHALL abort any conversion: state IDLE, ADSC=0, sample_req=0, result and ADIF retained; a late sample_ack SHALL be ignored.
REQ-023 ADCL/ADCH SHALL be read-only; writes ignored.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, ADCSRA=0, ADCSRB=0, ADMUX=0, result=10'h000, lock=0, prescaler=0, first-conversion flag=1.
REQ-025 Outputs during reset: sample_req=0, int_req=0, bus_out=0.
REQ-026 Reset mid-handshake SHALL drop sample_req the same cycle; release SHALL resume from IDLE only.

Structure
REQ-027 Shared package SHALL hold register address defaults, ADCSRA bit indices, ADTS encodings and FSM state encoding.
REQ-028 One sub-module atmega_adc_prescaler (ADPS in, enable in, tick out) SHALL be instantiated; remainder flat.

Verification
REQ-029 ADEN=1, ADPS=2, write ADSC=1 -> sample_req after 25x4=100 clk, ack data 10'h2A5 -> ADCH=02, ADCL=A5, ADIF=1, ADSC=0.
REQ-030 Second conversion ADPS=0, ADLAR=1, data 10'h3FF -> sample_req after 13x2=26 clk; ADCH=FF, ADCL=C0.
REQ-031 ADATE=1, ADTS=000, ADIE=1 -> back-to-back conversions, int_req high after first, int_ack clears ADIF same cycle as next set -> ADIF stays 1.
REQ-032 Read ADCL, complete conversion with 10'h155, read ADCH -> old result returned, ADIF=1; next read pair returns new value only after fresh conversion.
REQ-033 Clear ADEN during WAIT_DATA then pulse sample_ack -> state IDLE, ADSC=0, result unchanged.
REQ-034 Assert rst=0 asynchronously mid-CONVERT -> all registers 0, sample_req=0 before next clk edge.
